// File: rtl/regs_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regs_wb_arbiter: three-way write-back arbiter with a pending-write scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module regs_wb_arbiter #(
  parameter int unsigned AGE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_req,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_gnt,
  input  logic        mem_req,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_gnt,
  input  logic        dbg_req,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        dbg_gnt,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rd_addr_A,
  input  logic [4:0]  rd_addr_B,
  output logic        busy_A,
  output logic        busy_B,
  output logic        L_S,
  output logic [4:0]  Wt_addr,
  output logic [31:0] Wt_data
);

  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

  logic [3:0]  mem_wait_q, mem_wait_d;
  logic [3:0]  dbg_wait_q, dbg_wait_d;
  logic        mem_aged, dbg_aged;
  logic        gnt_any;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;
  logic        ls_q;
  logic [4:0]  wt_addr_q;
  logic [31:0] wt_data_q;
  logic [31:0] pending_q, pending_d;

  assign mem_aged = (mem_wait_q == AGE_MAX);
  assign dbg_aged = (dbg_wait_q == AGE_MAX);

  // Aged MEM/DBG requesters jump ahead of the fixed ALU > MEM > DBG order.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (mem_req && mem_aged)      mem_gnt = 1'b1;
      else if (dbg_req && dbg_aged) dbg_gnt = 1'b1;
      else if (alu_req)             alu_gnt = 1'b1;
      else if (mem_req)             mem_gnt = 1'b1;
      else if (dbg_req)             dbg_gnt = 1'b1;
    end
  end

  always_comb begin
    gnt_any  = alu_gnt | mem_gnt | dbg_gnt;
    gnt_addr = 5'd0;
    gnt_data = 32'd0;
    if (alu_gnt) begin
      gnt_addr = alu_addr;
      gnt_data = alu_data;
    end else if (mem_gnt) begin
      gnt_addr = mem_addr;
      gnt_data = mem_data;
    end else if (dbg_gnt) begin
      gnt_addr = dbg_addr;
      gnt_data = dbg_data;
    end
  end

  always_comb begin
    mem_wait_d = mem_wait_q;
    dbg_wait_d = dbg_wait_q;
    if (!mem_req || mem_gnt) mem_wait_d = 4'd0;
    else if (!mem_aged)      mem_wait_d = mem_wait_q + 4'd1;
    if (!dbg_req || dbg_gnt) dbg_wait_d = 4'd0;
    else if (!dbg_aged)      dbg_wait_d = dbg_wait_q + 4'd1;
  end

  // Clear on the committing edge first so a same-edge issue re-marks the register.
  always_comb begin
    pending_d = pending_q;
    if (ls_q) pending_d[wt_addr_q] = 1'b0;
    if (issue_valid) pending_d[issue_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_q       <= 1'b0;
      wt_addr_q  <= 5'd0;
      wt_data_q  <= 32'd0;
      pending_q  <= 32'd0;
      mem_wait_q <= 4'd0;
      dbg_wait_q <= 4'd0;
    end else begin
      ls_q       <= gnt_any && (gnt_addr != 5'd0);
      if (gnt_any) begin
        wt_addr_q <= gnt_addr;
        wt_data_q <= gnt_data;
      end
      pending_q  <= pending_d;
      mem_wait_q <= mem_wait_d;
      dbg_wait_q <= dbg_wait_d;
    end
  end

  assign busy_A  = !rst && pending_q[rd_addr_A];
  assign busy_B  = !rst && pending_q[rd_addr_B];
  assign L_S     = ls_q;
  assign Wt_addr = wt_addr_q;
  assign Wt_data = wt_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regs_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regs_wb_arbiter: directed and randomized checks against a reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_regs_wb_arbiter;
  localparam int AGE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_req, mem_req, dbg_req;
  logic [4:0]  alu_addr, mem_addr, dbg_addr;
  logic [31:0] alu_data, mem_data, dbg_data;
  logic        alu_gnt, mem_gnt, dbg_gnt;
  logic        issue_valid;
  logic [4:0]  issue_addr, rd_addr_A, rd_addr_B;
  logic        busy_A, busy_B, L_S;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;

  regs_wb_arbiter #(.AGE_LIMIT(AGE)) dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addr_A(rd_addr_A), .rd_addr_B(rd_addr_B),
    .busy_A(busy_A), .busy_B(busy_B),
    .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = none, 1 = ALU, 2 = MEM, 3 = DBG
  bit          m_pend[32];
  int          m_wait_mem, m_wait_dbg;
  bit          m_ls;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wait_mem = 0;
    m_wait_dbg = 0;
    m_ls = 1'b0;
    m_waddr = 5'd0;
    m_wdata = 32'd0;
  endtask

  function automatic bit req_of(input int k);
    return (k == 1) ? alu_req : (k == 2) ? mem_req : dbg_req;
  endfunction

  function automatic int pick_grant();
    int order[$];
    order = {};
    if (m_wait_mem == AGE) order.push_back(2);
    if (m_wait_dbg == AGE) order.push_back(3);
    order.push_back(1);
    order.push_back(2);
    order.push_back(3);
    foreach (order[i]) if (req_of(order[i])) return order[i];
    return 0;
  endfunction

  // Entered one time unit after a rising edge with inputs already applied.
  task automatic cycle();
    int g;
    logic [4:0]  ga;
    logic [31:0] gd;
    #3;
    g = pick_grant();
    chk("alu_gnt", alu_gnt, (g == 1));
    chk("mem_gnt", mem_gnt, (g == 2));
    chk("dbg_gnt", dbg_gnt, (g == 3));
    chk("busy_A", busy_A, (rd_addr_A != 0) && m_pend[rd_addr_A]);
    chk("busy_B", busy_B, (rd_addr_B != 0) && m_pend[rd_addr_B]);
    chk("L_S", L_S, m_ls);
    chk("Wt_addr", Wt_addr, m_waddr);
    chk("Wt_data", Wt_data, m_wdata);
    ga = (g == 1) ? alu_addr : (g == 2) ? mem_addr : dbg_addr;
    gd = (g == 1) ? alu_data : (g == 2) ? mem_data : dbg_data;
    if (m_ls) m_pend[m_waddr] = 1'b0;
    if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    m_wait_mem = (mem_req && g != 2) ? ((m_wait_mem + 1 > AGE) ? AGE : m_wait_mem + 1) : 0;
    m_wait_dbg = (dbg_req && g != 3) ? ((m_wait_dbg + 1 > AGE) ? AGE : m_wait_dbg + 1) : 0;
    if (g != 0) begin
      m_ls = (ga != 0);
      m_waddr = ga;
      m_wdata = gd;
    end else begin
      m_ls = 1'b0;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {alu_req, mem_req, dbg_req, issue_valid} = '0;
    {alu_addr, mem_addr, dbg_addr, issue_addr, rd_addr_A, rd_addr_B} = '0;
    {alu_data, mem_data, dbg_data} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_L_S", L_S, 0);
    chk("rst_Wt_addr", Wt_addr, 0);
    chk("rst_Wt_data", Wt_data, 0);
    rst = 1'b0;

    // Simultaneous requests resolve ALU, MEM, DBG on consecutive cycles
    alu_req = 1; alu_addr = 5'd3; alu_data = 32'h11;
    mem_req = 1; mem_addr = 5'd4; mem_data = 32'h22;
    dbg_req = 1; dbg_addr = 5'd5; dbg_data = 32'h33;
    cycle(); chk("sim_g0", last_g, 1); alu_req = 0;
    chk("sim_ls1", L_S, 1); chk("sim_wa1", Wt_addr, 3);
    cycle(); chk("sim_g1", last_g, 2); mem_req = 0;
    chk("sim_ls2", L_S, 1); chk("sim_wa2", Wt_addr, 4);
    cycle(); chk("sim_g2", last_g, 3); dbg_req = 0;
    chk("sim_ls3", L_S, 1); chk("sim_wa3", Wt_addr, 5); chk("sim_wd3", Wt_data, 32'h33);
    cycle(); chk("sim_ls4", L_S, 0);

    // MEM starved by continuous ALU requests gets promoted after AGE denials
    alu_req = 1; alu_addr = 5'd10; alu_data = 32'hA0;
    mem_req = 1; mem_addr = 5'd11; mem_data = 32'hB0;
    for (int i = 0; i < AGE; i++) begin
      cycle(); chk("age_alu", last_g, 1);
    end
    cycle(); chk("age_mem", last_g, 2); mem_req = 0;
    cycle(); chk("age_alu_after", last_g, 1); alu_req = 0;
    cycle();

    // Scoreboard: busy from issue until the write commits
    issue_valid = 1; issue_addr = 5'd7; rd_addr_A = 5'd7;
    cycle(); issue_valid = 0;
    chk("sb_busy1", busy_A, 1);
    cycle();
    alu_req = 1; alu_addr = 5'd7; alu_data = 32'h77;
    cycle(); chk("sb_gnt", last_g, 1); alu_req = 0;
    chk("sb_busy3", busy_A, 1); chk("sb_ls3", L_S, 1);
    cycle(); chk("sb_busy4", busy_A, 0);

    // Set wins over a same-edge clear
    issue_valid = 1; issue_addr = 5'd9; rd_addr_B = 5'd9;
    cycle(); issue_valid = 0;
    alu_req = 1; alu_addr = 5'd9; alu_data = 32'h99;
    cycle(); alu_req = 0;
    chk("col_ls", L_S, 1); chk("col_wa", Wt_addr, 9);
    issue_valid = 1; issue_addr = 5'd9;
    cycle(); issue_valid = 0;
    chk("col_busy", busy_B, 1);
    cycle(); chk("col_busy2", busy_B, 1);

    // Register 0 is never pending and never written
    issue_valid = 1; issue_addr = 5'd0; rd_addr_A = 5'd0;
    cycle(); issue_valid = 0;
    chk("r0_busy", busy_A, 0);
    dbg_req = 1; dbg_addr = 5'd0; dbg_data = 32'h55;
    cycle(); chk("r0_gnt", last_g, 3); dbg_req = 0;
    chk("r0_ls", L_S, 0);
    cycle();

    // Asynchronous reset while a write is in flight
    alu_req = 1; alu_addr = 5'd12; alu_data = 32'hC0FFEE;
    cycle(); alu_req = 0;
    chk("ar_ls_pre", L_S, 1);
    mem_req = 1; mem_addr = 5'd13; mem_data = 32'h1;
    #2; rst = 1'b1; #1;
    chk("ar_ls", L_S, 0); chk("ar_wa", Wt_addr, 0); chk("ar_wd", Wt_data, 0);
    chk("ar_mem_gnt", mem_gnt, 0); chk("ar_busy_B", busy_B, 0);
    model_reset();
    mem_req = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(); chk("ar_no_write", L_S, 0);

    // Randomized traffic obeying the hold-until-granted handshake
    for (int n = 0; n < 400; n++) begin
      if (!alu_req && $urandom_range(0, 3) != 0) begin
        alu_req = 1; alu_addr = 5'($urandom); alu_data = $urandom;
      end
      if (!mem_req && $urandom_range(0, 1) != 0) begin
        mem_req = 1; mem_addr = 5'($urandom); mem_data = $urandom;
      end
      if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1; dbg_addr = 5'($urandom); dbg_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = 5'($urandom);
      rd_addr_A   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rd_addr_B   = 5'($urandom);
      cycle();
      if (last_g == 1) alu_req = 0;
      if (last_g == 2) mem_req = 0;
      if (last_g == 3) dbg_req = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regs_wb_arbiter.md
# regs_wb_arbiter

Write-back arbiter and scoreboard for the 32 x 32-bit register file. It shares the file's single write port among three requesters: ALU write-back, memory load return and the debug/monitor port. It drives the file's L_S / Wt_addr / Wt_data inputs from a registered stage. It also tracks outstanding writes per register, so the issue logic can stall on read-after-write hazards through busy_A / busy_B.

## Interface
Parameters:
- AGE_LIMIT, default 4: consecutive denied cycles after which a MEM or DBG requester is promoted above ALU; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- alu_req  input  1  ALU write request; held until granted
- alu_addr  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_gnt  output  1  ALU grant (combinational)
- mem_req / mem_addr / mem_data / mem_gnt  in/in/in/out  1/5/32/1  load-return requester, same rules as ALU
- dbg_req / dbg_addr / dbg_data / dbg_gnt  in/in/in/out  1/5/32/1  debug requester, same rules as ALU
- issue_valid  input  1  an instruction with destination issue_addr is issued this cycle
- issue_addr  input  5  destination register of issued instruction
- rd_addr_A  input  5  read address A, same value as the register file's R_addr_A
- rd_addr_B  input  5  read address B, same value as the register file's R_addr_B
- busy_A  output  1  register rd_addr_A has a pending write (combinational)
- busy_B  output  1  register rd_addr_B has a pending write (combinational)
- L_S  output  1  register-file write enable (registered)
- Wt_addr  output  5  register-file write address (registered)
- Wt_data  output  32  register-file write data (registered)

## Operation
Handshake:
- A requester raises req with addr/data stable and keeps them stable until the cycle in which its gnt is 1.
- The transfer completes on the rising edge that ends a cycle with req=1 and gnt=1.
- Exactly one gnt is high in any cycle, or none.

Arbitration:
- Per-cycle priority is ALU > MEM > DBG.
- Exception: aged requesters go first. A requester is aged when its wait counter equals AGE_LIMIT. If both MEM and DBG are aged, MEM wins, then DBG.
- Aged requesters are ordered ahead of ALU.

Wait counters (MEM and DBG only, 4-bit):
- +1 on each edge where req=1 and gnt=0.
- Saturate at AGE_LIMIT.
- Clear to 0 on an edge where gnt=1 or req=0.

Write stage:
- On an edge with any grant: L_S<=1, Wt_addr<=granted addr, Wt_data<=granted data.
- On an edge with no grant: L_S<=0; Wt_addr and Wt_data hold.
- A granted write to addr 0 is consumed but produces L_S<=0.

Scoreboard (pending[31:1]):
- pending[issue_addr] is set on an edge with issue_valid=1 and issue_addr!=0.
- pending[Wt_addr] is cleared on an edge with L_S=1, i.e. the same edge on which the register file writes.
- If set and clear target the same register on the same edge, set wins.
- busy_X = pending[rd_addr_X]; busy_X is 0 when rd_addr_X=0.

## Timing
- Reset (asynchronous): L_S=0, Wt_addr=0, Wt_data=0, pending all 0, wait counters 0.
- While rst=1, alu_gnt, mem_gnt, dbg_gnt, busy_A and busy_B are forced to 0.
- Requests raised in the cycle rst deasserts are arbitrated normally.
- Latency: a request granted in cycle n drives L_S=1 during cycle n+1. The register file holds the new value from cycle n+2, and busy drops in cycle n+2.
- Throughput: one write per cycle; back-to-back grants give continuous L_S=1.
- Reset mid-operation: any write captured but not yet committed (L_S=1) is dropped. Pending bits are lost. Requesters must re-request after reset.
- A write whose Wt_addr has no pending bit set (e.g. a debug write) clears nothing and needs no error handling.

## Test plan
- Reset: assert rst mid-write with L_S=1 -> L_S=0, Wt_addr=0, Wt_data=0, all gnt=0 and busy=0 immediately without a clock edge; release rst, no write issued.
- Simultaneous requests: alu_req(addr 3, 0x11), mem_req(addr 4, 0x22), dbg_req(addr 5, 0x33) in cycle 0 -> grants ALU in cycle 0, MEM in cycle 1, DBG in cycle 2. L_S=1 for cycles 1-3 with Wt_addr 3, 4, 5.
- Aging with AGE_LIMIT=4: alu_req held high continuously while mem_req held -> MEM denied in cycles 0-3, mem_gnt=1 in cycle 4. ALU is then granted again in cycle 5 and the MEM counter reads 0.
- Scoreboard: issue_valid with addr 7 in cycle 0, rd_addr_A=7 -> busy_A=1 from cycle 1. alu write to 7 granted in cycle 2 -> L_S=1 in cycle 3, busy_A=0 in cycle 4.
- Set-wins collision: L_S=1 with Wt_addr=9 on the same edge as issue_valid with addr 9 -> busy for register 9 stays 1.
- Register 0: issue_valid with addr 0 -> no pending bit set. dbg write to addr 0 -> dbg_gnt=1, next cycle L_S=0. busy_A=0 with rd_addr_A=0.
